fetch_unit: RTL and testbench

- Instruction-fetch stage of the rv64 in-order pipeline.
- Owns the PC register, the instruction-memory request/response handshake and the IF/ID pipeline register.
- Consumes the stall/bubble controls that the pipeline's hazard detection produces (freeze PC, freeze IF/ID) and the branch/jump redirect from EX.
- Guarantees no instruction is lost or duplicated across stalls, redirects and variable memory latency.

---
 rtl/fetch_unit.sv | 137 +++++++++++++
 tb/tb_fetch_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, single-outstanding imem handshake, 1-entry hold
// buffer and the IF/ID register, with redirect flush and stale-response kill.
module fetch_unit #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            stall_if_i,
  input  logic            stall_id_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  output logic            id_valid_o,
  output logic [31:0]     id_instr_o,
  output logic [XLEN-1:0] id_pc_o
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {S_REQ = 1'b0, S_WAIT = 1'b1} state_e;

  state_e          state_q, state_d;
  logic            kill_q, kill_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q;

  logic            hold_valid_q;
  logic [31:0]     hold_instr_q;
  logic [XLEN-1:0] hold_pc_q;

  logic            id_valid_q;
  logic [31:0]     id_instr_q;
  logic [XLEN-1:0] id_pc_q;

  logic            grant;
  logic            resp;

  assign grant = imem_req_o & imem_gnt_i;
  assign resp  = (state_q == S_WAIT) & imem_rvalid_i & ~kill_q;

  // FSM: state register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= S_REQ;
    else         state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_REQ:   if (grant)         state_d = S_WAIT;
      S_WAIT:  if (imem_rvalid_i) state_d = S_REQ;
      default:                    state_d = S_REQ;
    endcase
  end

  // FSM: outputs. kill_q blocks new requests until the stale response drains.
  always_comb begin
    imem_req_o  = rst_ni & (state_q == S_REQ) & ~stall_if_i & ~hold_valid_q
                & ~redirect_i & ~kill_q;
    imem_addr_o = pc_q;
  end

  // A response landing in the redirect cycle is dropped right there; only a
  // still-outstanding one needs kill to catch it later.
  always_comb begin
    kill_d = kill_q;
    if (imem_rvalid_i && kill_q) kill_d = 1'b0;
    if (redirect_i && (state_q == S_WAIT) && !imem_rvalid_i) kill_d = 1'b1;
  end

  always_comb begin
    pc_d = pc_q;
    if (redirect_i) pc_d = {redirect_pc_i[XLEN-1:2], 2'b00};
    else if (grant) pc_d = pc_q + XLEN'(4);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pc_q     <= {RESET_PC[XLEN-1:2], 2'b00};
      kill_q   <= (state_q == S_WAIT) & ~imem_rvalid_i;
      req_pc_q <= '0;
    end else begin
      pc_q   <= pc_d;
      kill_q <= kill_d;
      if (grant) req_pc_q <= pc_q;
    end
  end

  // IF/ID and hold buffer; the hold entry always drains ahead of a new response
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      id_valid_q   <= 1'b0;
      id_instr_q   <= NOP;
      id_pc_q      <= '0;
      hold_valid_q <= 1'b0;
      hold_instr_q <= NOP;
      hold_pc_q    <= '0;
    end else if (redirect_i) begin
      id_valid_q   <= 1'b0;
      id_instr_q   <= NOP;
      hold_valid_q <= 1'b0;
    end else if (stall_id_i) begin
      if (resp) begin
        hold_valid_q <= 1'b1;
        hold_instr_q <= imem_rdata_i;
        hold_pc_q    <= req_pc_q;
      end
    end else if (hold_valid_q) begin
      id_valid_q <= 1'b1;
      id_instr_q <= hold_instr_q;
      id_pc_q    <= hold_pc_q;
      if (resp) begin
        hold_instr_q <= imem_rdata_i;
        hold_pc_q    <= req_pc_q;
      end else begin
        hold_valid_q <= 1'b0;
      end
    end else if (resp) begin
      id_valid_q <= 1'b1;
      id_instr_q <= imem_rdata_i;
      id_pc_q    <= req_pc_q;
    end else begin
      id_valid_q <= 1'b0;
    end
  end

  assign id_valid_o = id_valid_q;
  assign id_instr_o = id_instr_q;
  assign id_pc_o    = id_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed vector table for fetch_unit plus a scripted multi-fetch sequence
// with a small memory responder checking in-order, lossless delivery.
module tb_fetch_unit;

  localparam logic [63:0] R   = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] BAD = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n, sif, sid, rd, gnt, rv;
  logic [63:0] rpc;
  logic [31:0] rdata;
  logic        req, idv;
  logic [63:0] addr, idp;
  logic [31:0] idi;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk_i(clk), .rst_ni(rst_n), .stall_if_i(sif), .stall_id_i(sid),
    .redirect_i(rd), .redirect_pc_i(rpc),
    .imem_req_o(req), .imem_addr_o(addr), .imem_gnt_i(gnt),
    .imem_rvalid_i(rv), .imem_rdata_i(rdata),
    .id_valid_o(idv), .id_instr_o(idi), .id_pc_o(idp)
  );

  typedef struct {
    logic        rst_n, sif, sid, rd;
    logic [63:0] rpc;
    logic        gnt, rv;
    logic [31:0] rdata;
    logic        req;
    logic [63:0] addr;
    logic        idv;
    logic [31:0] idi;
    logic [63:0] idp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic r, si, sd, re, input logic [63:0] rp,
                             input logic g, va, input logic [31:0] d,
                             input logic eq, input logic [63:0] ea,
                             input logic ev, input logic [31:0] ei, input logic [63:0] ep);
    vec_t t;
    t.rst_n = r; t.sif = si; t.sid = sd; t.rd = re; t.rpc = rp;
    t.gnt = g; t.rv = va; t.rdata = d;
    t.req = eq; t.addr = ea; t.idv = ev; t.idi = ei; t.idp = ep;
    return t;
  endfunction

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ 32'h5A5A_0000;
  endfunction

  task automatic drive(input logic r, si, sd, re, input logic [63:0] rp,
                       input logic g, va, input logic [31:0] d);
    rst_n = r; sif = si; sid = sd; rd = re; rpc = rp; gnt = g; rv = va; rdata = d;
  endtask

  initial begin
    logic [63:0] pend_addr, exp_pc;
    logic        pend, granted, stl;
    int          cnt, consumed, cyc;

    // reset/basic fetch
    tbl.push_back(v(0,0,0,0,0,        0,0,0,          0,R,       0,NOP,0));
    tbl.push_back(v(1,0,0,0,0,        1,0,0,          1,R,       0,NOP,0));
    tbl.push_back(v(1,0,0,0,0,        1,1,32'h00100093,0,R+4,    0,NOP,0));
    tbl.push_back(v(1,0,0,0,0,        1,0,0,          1,R+4,     1,32'h00100093,R));
    tbl.push_back(v(1,0,0,0,0,        0,1,32'h00200113,0,R+8,    0,32'h00100093,R));
    // load-use stall parks response in hold buffer
    tbl.push_back(v(1,0,0,0,0,        1,0,0,          1,R+8,     1,32'h00200113,R+4));
    tbl.push_back(v(1,1,1,0,0,        0,1,32'h00300193,0,R+'hC,  0,32'h00200113,R+4));
    tbl.push_back(v(1,0,0,0,0,        1,0,0,          0,R+'hC,   0,32'h00200113,R+4));
    tbl.push_back(v(1,0,0,0,0,        1,0,0,          1,R+'hC,   1,32'h00300193,R+8));
    tbl.push_back(v(1,0,0,0,0,        0,1,32'h00400213,0,R+'h10, 0,32'h00300193,R+8));
    // redirect while waiting: stale response killed
    tbl.push_back(v(1,0,0,0,0,        1,0,0,          1,R+'h10,  1,32'h00400213,R+'hC));
    tbl.push_back(v(1,0,0,1,R+'h100,  0,0,0,          0,R+'h14,  0,32'h00400213,R+'hC));
    tbl.push_back(v(1,0,0,0,0,        0,0,0,          0,R+'h100, 0,NOP,R+'hC));
    tbl.push_back(v(1,0,0,0,0,        1,1,BAD,        0,R+'h100, 0,NOP,R+'hC));
    tbl.push_back(v(1,0,0,0,0,        1,0,0,          1,R+'h100, 0,NOP,R+'hC));
    tbl.push_back(v(1,0,0,0,0,        0,1,32'h00500293,0,R+'h104,0,NOP,R+'hC));
    tbl.push_back(v(1,0,0,0,0,        0,0,0,          1,R+'h104, 1,32'h00500293,R+'h100));
    // grant withheld three cycles
    tbl.push_back(v(1,0,0,0,0,        0,0,0,          1,R+'h104, 0,32'h00500293,R+'h100));
    tbl.push_back(v(1,0,0,0,0,        0,0,0,          1,R+'h104, 0,32'h00500293,R+'h100));
    tbl.push_back(v(1,0,0,0,0,        0,0,0,          1,R+'h104, 0,32'h00500293,R+'h100));
    tbl.push_back(v(1,0,0,0,0,        1,0,0,          1,R+'h104, 0,32'h00500293,R+'h100));
    tbl.push_back(v(1,0,0,0,0,        0,1,32'h00600313,0,R+'h108,0,32'h00500293,R+'h100));
    // redirect (misaligned) coinciding with rvalid under stall_id
    tbl.push_back(v(1,0,1,0,0,        1,0,0,          1,R+'h108, 1,32'h00600313,R+'h104));
    tbl.push_back(v(1,1,1,1,R+'h202,  0,1,BAD,        0,R+'h10C, 1,32'h00600313,R+'h104));
    tbl.push_back(v(1,0,1,0,0,        1,0,0,          1,R+'h200, 0,NOP,R+'h104));
    tbl.push_back(v(1,0,0,0,0,        0,1,32'h00700393,0,R+'h204,0,NOP,R+'h104));
    tbl.push_back(v(1,0,0,0,0,        0,0,0,          1,R+'h204, 1,32'h00700393,R+'h200));
    // redirect flushes a full hold buffer
    tbl.push_back(v(1,0,0,0,0,        1,0,0,          1,R+'h204, 0,32'h00700393,R+'h200));
    tbl.push_back(v(1,0,1,0,0,        0,1,32'h00800413,0,R+'h208,0,32'h00700393,R+'h200));
    tbl.push_back(v(1,0,1,1,R+'h300,  0,0,0,          0,R+'h208, 0,32'h00700393,R+'h200));
    tbl.push_back(v(1,0,0,0,0,        0,0,0,          1,R+'h300, 0,NOP,R+'h200));
    tbl.push_back(v(1,0,0,0,0,        0,0,0,          1,R+'h300, 0,NOP,R+'h200));
    // reset in WAIT; late response dropped
    tbl.push_back(v(1,0,0,0,0,        1,0,0,          1,R+'h300, 0,NOP,R+'h200));
    tbl.push_back(v(0,0,0,0,0,        0,0,0,          0,R+'h304, 0,NOP,R+'h200));
    tbl.push_back(v(1,0,0,0,0,        1,0,0,          0,R,       0,NOP,0));
    tbl.push_back(v(1,0,0,0,0,        1,1,BAD,        0,R,       0,NOP,0));
    tbl.push_back(v(1,0,0,0,0,        1,0,0,          1,R,       0,NOP,0));
    tbl.push_back(v(1,0,0,0,0,        0,1,32'h00900493,0,R+4,    0,NOP,0));
    tbl.push_back(v(1,0,0,0,0,        0,0,0,          1,R+4,     1,32'h00900493,R));
    // pc wraps at the top of the address space
    tbl.push_back(v(1,0,0,1,64'hFFFF_FFFF_FFFF_FFFC,0,0,0, 0,R+4, 0,32'h00900493,R));
    tbl.push_back(v(1,0,0,0,0,        1,0,0,          1,64'hFFFF_FFFF_FFFF_FFFC,0,NOP,R));
    tbl.push_back(v(1,0,0,0,0,        0,1,32'h00a00513,0,64'h0,  0,NOP,R));
    tbl.push_back(v(1,0,0,0,0,        0,0,0,          1,64'h0,   1,32'h00a00513,64'hFFFF_FFFF_FFFF_FFFC));

    drive(0,0,0,0,0,0,0,0);
    repeat (2) @(posedge clk);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i].rst_n, tbl[i].sif, tbl[i].sid, tbl[i].rd, tbl[i].rpc,
            tbl[i].gnt, tbl[i].rv, tbl[i].rdata);
      #1;
      checks++;
      if (req !== tbl[i].req || addr !== tbl[i].addr || idv !== tbl[i].idv ||
          idi !== tbl[i].idi || idp !== tbl[i].idp) begin
        errors++;
        $display("FAIL vec%0d: got req=%0b addr=%h idv=%0b instr=%h pc=%h, want req=%0b addr=%h idv=%0b instr=%h pc=%h",
                 i, req, addr, idv, idi, idp,
                 tbl[i].req, tbl[i].addr, tbl[i].idv, tbl[i].idi, tbl[i].idp);
      end
    end

    // multi-fetch with stalls, withheld grants and variable latency
    @(negedge clk);
    drive(1,0,0,1,64'h8000_1000,0,0,0);
    pend = 0; pend_addr = 0; cnt = 0; consumed = 0; cyc = 0;
    exp_pc = 64'h8000_1000;
    while (consumed < 8 && cyc < 300) begin
      @(negedge clk);
      stl = (cyc % 5 == 2) || (cyc % 7 == 3);
      drive(1, stl, stl, 0, 0, (cyc % 3 != 1), pend && cnt == 0,
            (pend && cnt == 0) ? mem_word(pend_addr) : BAD);
      #1;
      granted = req && gnt;
      if (granted) begin
        checks++;
        if (pend) begin
          errors++;
          $display("FAIL outstanding: got second grant at addr=%h, want none while %h pending", addr, pend_addr);
        end
      end
      if (idv && !stl) begin
        checks++;
        if (idp !== exp_pc || idi !== mem_word(exp_pc)) begin
          errors++;
          $display("FAIL seq%0d: got pc=%h instr=%h, want pc=%h instr=%h",
                   consumed, idp, idi, exp_pc, mem_word(exp_pc));
        end
        exp_pc += 64'd4;
        consumed++;
      end
      if (rv) pend = 0;
      else if (pend) cnt--;
      if (granted) begin
        pend = 1;
        pend_addr = addr;
        cnt = cyc % 3;
      end
      cyc++;
    end
    checks++;
    if (consumed != 8) begin
      errors++;
      $display("FAIL seq_timeout: got %0d instructions, want 8 within 300 cycles", consumed);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
